// File: rtl/ssf_core.sv
// rtl/ssf_core.sv - frame-scheduled single-port FIR core with a serial MAC
// One sample request per frame, NTAPS serial MACs, then one registered result.
module ssf_core #(
  parameter int                NTAPS  = 16,
  parameter int                PERIOD = 32175,
  parameter logic [16*NTAPS-1:0] COEF = {NTAPS{16'sd2048}}
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] io_in,
  output logic [31:0] io_out,
  output logic [1:0]  req_in,
  output logic [1:0]  out_en
);

  localparam int FCW = $clog2(PERIOD);
  localparam int TW  = (NTAPS > 1) ? $clog2(NTAPS) : 1;

  localparam logic [FCW-1:0] FC_LAST  = FCW'(PERIOD - 1);
  localparam logic [FCW-1:0] FC_CAP   = FCW'(1);
  localparam logic [FCW-1:0] FC_MAC0  = FCW'(2);
  localparam logic [FCW-1:0] FC_MACN  = FCW'(NTAPS + 1);
  localparam logic [FCW-1:0] FC_LOAD  = FCW'(NTAPS + 2);

  logic                run_q;
  logic [FCW-1:0]      fc_q, fc_d;
  logic signed [31:0]  x_q [NTAPS];
  logic signed [31:0]  x_d [NTAPS];
  logic signed [47:0]  acc_q, acc_d;
  logic [31:0]         out_q, out_d;
  logic                vld_q, vld_d;

  logic signed [15:0]  coef_w [NTAPS];
  logic [TW-1:0]       tap;
  logic signed [31:0]  x_sel;
  logic signed [15:0]  c_sel;
  logic signed [47:0]  prod;

  for (genvar k = 0; k < NTAPS; k++) begin : g_coef
    assign coef_w[k] = COEF[16*k +: 16];
  end

  assign tap   = TW'(fc_q - FC_MAC0);
  assign x_sel = x_q[tap];
  assign c_sel = coef_w[tap];
  assign prod  = 48'(x_sel) * 48'(c_sel);

  // run_q holds fc at 0 through the first post-reset edge so that frame 0 starts there.
  always_comb begin
    fc_d  = fc_q;
    x_d   = x_q;
    acc_d = acc_q;
    out_d = out_q;
    vld_d = 1'b0;
    if (run_q) begin
      fc_d = (fc_q == FC_LAST) ? '0 : fc_q + FCW'(1);
      if (fc_q == FC_CAP) begin
        x_d[0] = io_in;
        for (int k = 1; k < NTAPS; k++) x_d[k] = x_q[k-1];
        acc_d = '0;
      end else if (fc_q >= FC_MAC0 && fc_q <= FC_MACN) begin
        acc_d = acc_q + prod;
      end else if (fc_q == FC_LOAD) begin
        out_d = acc_q[46:15];
        vld_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      run_q <= 1'b0;
      fc_q  <= '0;
      acc_q <= '0;
      out_q <= '0;
      vld_q <= 1'b0;
      for (int k = 0; k < NTAPS; k++) x_q[k] <= '0;
    end else begin
      run_q <= 1'b1;
      fc_q  <= fc_d;
      acc_q <= acc_d;
      out_q <= out_d;
      vld_q <= vld_d;
      for (int k = 0; k < NTAPS; k++) x_q[k] <= x_d[k];
    end
  end

  assign io_out = out_q;
  assign req_in = {1'b0, run_q && (fc_q == '0)};
  assign out_en = {1'b0, vld_q};

endmodule

// File: tb/tb_ssf_core.sv
// tb/tb_ssf_core.sv - randomized self-checking bench for ssf_core
// Two cores (default and mixed-sign coefficients) share io_in; a FIR history model predicts results.
module tb_ssf_core;

  localparam int NTAPS  = 16;
  localparam int PERIOD = 40;
  localparam logic [16*NTAPS-1:0] COEF_B = {
    -16'sd1000, 16'sd600, 16'sd1100, -16'sd1800, 16'sd300, 16'sd2200, -16'sd700, 16'sd1500,
    16'sd900, -16'sd2600, 16'sd1700, -16'sd400, 16'sd800, 16'sd2500, -16'sd1200, 16'sd3000};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] io_in = '0;
  logic [31:0] out_a, out_b;
  logic [1:0]  req_a, req_b, en_a, en_b;

  int          checks = 0;
  int          errors = 0;
  int          cyc;
  longint      hist [NTAPS];
  int          coef_a [NTAPS];
  int          coef_b [NTAPS] = '{3000, -1200, 2500, 800, -400, 1700, -2600, 900,
                                  1500, -700, 2200, 300, -1800, 1100, 600, -1000};
  logic [31:0] pend_a, pend_b, hold_a, hold_b, frame_res;

  ssf_core #(.NTAPS(NTAPS), .PERIOD(PERIOD)) dut_a (
    .clk(clk), .rst(rst), .io_in(io_in), .io_out(out_a), .req_in(req_a), .out_en(en_a));

  ssf_core #(.NTAPS(NTAPS), .PERIOD(PERIOD), .COEF(COEF_B)) dut_b (
    .clk(clk), .rst(rst), .io_in(io_in), .io_out(out_b), .req_in(req_b), .out_en(en_b));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] fir(input int c [NTAPS]);
    longint s = 0;
    for (int k = 0; k < NTAPS; k++) s += hist[k] * longint'(c[k]);
    s = s >>> 15;
    return s[31:0];
  endfunction

  task automatic clear_model();
    for (int k = 0; k < NTAPS; k++) hist[k] = 0;
    pend_a = '0; pend_b = '0; hold_a = '0; hold_b = '0;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) begin
      @(negedge clk);
      check("rst_req", {28'b0, req_a, req_b}, 32'd0);
      check("rst_en", {28'b0, en_a, en_b}, 32'd0);
      check("rst_out_a", out_a, 32'd0);
      check("rst_out_b", out_b, 32'd0);
    end
    clear_model();
    rst   = 1'b0;
    cyc   = 0;
    io_in = $urandom;
  endtask

  task automatic step(input logic [31:0] samp);
    int fc;
    @(negedge clk);
    fc = cyc % PERIOD;
    if (fc == NTAPS + 3) begin
      hold_a = pend_a;
      hold_b = pend_b;
      frame_res = out_a;
    end
    check("req_a", 32'(req_a), (fc == 0) ? 32'd1 : 32'd0);
    check("req_b", 32'(req_b), (fc == 0) ? 32'd1 : 32'd0);
    check("en_a", 32'(en_a), (fc == NTAPS + 3) ? 32'd1 : 32'd0);
    check("en_b", 32'(en_b), (fc == NTAPS + 3) ? 32'd1 : 32'd0);
    check("out_a", out_a, hold_a);
    check("out_b", out_b, hold_b);
    if (fc == 1) begin
      io_in = samp;
      for (int k = NTAPS - 1; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = longint'($signed(samp));
      pend_a = fir(coef_a);
      pend_b = fir(coef_b);
    end else begin
      io_in = $urandom;
    end
    cyc++;
  endtask

  task automatic run_frame(input logic [31:0] samp);
    repeat (PERIOD) step(samp);
  endtask

  initial begin
    for (int k = 0; k < NTAPS; k++) coef_a[k] = 2048;
    cyc = 0;
    frame_res = '0;
    clear_model();

    do_reset(3);
    for (int f = 1; f <= 17; f++) begin
      run_frame(32'd1600);
      if (f == 1)  check("const1600_f1", frame_res, 32'd100);
      if (f == 2)  check("const1600_f2", frame_res, 32'd200);
      if (f >= 16) check("const1600_hold", frame_res, 32'd1600);
    end

    do_reset(2);
    for (int f = 1; f <= 18; f++) begin
      run_frame((f == 1) ? 32'd16000 : 32'd0);
      if (f <= 16) check("impulse_on", frame_res, 32'd1000);
      else         check("impulse_off", frame_res, 32'd0);
    end

    do_reset(2);
    run_frame(32'hFFFF_FFFF);
    check("neg1_floor", frame_res, 32'hFFFF_FFFF);
    for (int f = 1; f <= 16; f++) run_frame(32'hFFFF_FFE0);
    check("neg32_settle", frame_res, 32'hFFFF_FFE0);
    for (int f = 1; f <= 16; f++) run_frame(32'h7FFF_FFFF);
    check("max_settle", frame_res, 32'h7FFF_FFFF);

    for (int f = 1; f <= 20; f++) run_frame($urandom);

    do_reset(2);
    repeat (11) step(32'd160);
    do_reset(2);
    run_frame(32'd160);
    check("abort_restart", frame_res, 32'd10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
